// File: rtl/aes_pkg.sv
// ---- aes_pkg : shared types and round-count helper for the AES round sequencer -- rev 1.0 ----
`default_nettype none
package aes_pkg;

  typedef enum logic [1:0] {
    KS_128  = 2'b00,
    KS_192  = 2'b01,
    KS_256  = 2'b10,
    KS_RSVD = 2'b11
  } key_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FINAL = 2'd3
  } sched_state_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // The reserved encoding falls back to the 128-bit round count.
  function automatic logic [3:0] nr_of(input key_size_e ks);
    case (ks)
      KS_192:  nr_of = NR_192;
      KS_256:  nr_of = NR_256;
      default: nr_of = NR_128;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_rr_arbiter.sv
// ---- aes_rr_arbiter : combinational round-robin pick, scanning upward from ptr+1 -- rev 1.0 ----
`default_nettype none
module aes_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (en && (grant == '0) && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_round_sched.sv
// ---- aes_round_sched : job arbiter and round sequencer for AES-128/192/256 -- rev 1.0 ----
`default_nettype none
module aes_round_sched
  import aes_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_mode,
  input  logic [NUM_REQ-1:0]   req_enc_dec,
  input  logic                 abort,
  output logic [3:0]           round,
  output logic                 load,
  output logic                 last_round,
  output logic                 enc_dec_reg,
  output logic [1:0]           mode_reg,
  output logic                 busy,
  output logic                 done,
  output logic [ID_W-1:0]      done_id,
  output logic                 err
);

  sched_state_e        state, state_n;
  logic [3:0]          round_q, round_n, nr_q;
  logic [ID_W-1:0]     rr_ptr, job_id, grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                err_q, enc_q, accept;
  key_size_e           mode_q, sel_mode;

  aes_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        ((state == IDLE) && !abort),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept   = |grant;
  assign sel_mode = key_size_e'(req_mode[2*int'(grant_idx) +: 2]);

  always_comb begin
    state_n = state;
    round_n = round_q;
    case (state)
      IDLE: begin
        round_n = 4'd0;
        if (accept) state_n = LOAD;
      end
      LOAD: begin
        state_n = RUN;
        round_n = 4'd1;
      end
      RUN: begin
        if (round_q == nr_q - 4'd1) begin
          state_n = FINAL;
          round_n = nr_q;
        end else begin
          round_n = round_q + 4'd1;
        end
      end
      FINAL: begin
        state_n = IDLE;
        round_n = 4'd0;
      end
      default: begin
        state_n = IDLE;
        round_n = 4'd0;
      end
    endcase
    // Abort cancels any active job; the arbiter pointer is left on the aborted id.
    if (abort && (state != IDLE)) begin
      state_n = IDLE;
      round_n = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      round_q <= 4'd0;
      nr_q    <= NR_128;
      rr_ptr  <= ID_W'(NUM_REQ - 1);
      job_id  <= '0;
      err_q   <= 1'b0;
      enc_q   <= 1'b0;
      mode_q  <= KS_128;
    end else begin
      state   <= state_n;
      round_q <= round_n;
      if (accept) begin
        rr_ptr <= grant_idx;
        job_id <= grant_idx;
        mode_q <= sel_mode;
        nr_q   <= nr_of(sel_mode);
        err_q  <= (sel_mode == KS_RSVD);
        enc_q  <= req_enc_dec[grant_idx];
      end
    end
  end

  assign req_ready   = grant;
  assign round       = round_q;
  assign load        = (state == LOAD);
  assign last_round  = (state == FINAL);
  assign busy        = (state != IDLE);
  assign done        = (state == FINAL) && !abort;
  assign done_id     = done ? job_id : '0;
  assign err         = done && err_q;
  assign enc_dec_reg = enc_q;
  assign mode_reg    = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sched.sv
// ---- tb_aes_round_sched : randomized bench against a job-age reference model -- rev 1.0 ----
`default_nettype none
module tb_aes_round_sched;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_REQ-1:0] req_valid, req_ready, req_enc_dec;
  logic [3:0]         req_mode;
  logic               abort;
  logic [3:0]         round;
  logic               load, last_round, enc_dec_reg, busy, done, err;
  logic [1:0]         mode_reg;
  logic [ID_W-1:0]    done_id;

  aes_round_sched #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_enc_dec(req_enc_dec), .abort(abort), .round(round),
    .load(load), .last_round(last_round), .enc_dec_reg(enc_dec_reg), .mode_reg(mode_reg),
    .busy(busy), .done(done), .done_id(done_id), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_now = 0;

  // Reference model: a job is described only by how many cycles it has been active.
  bit         m_busy;
  int         m_age, m_nr, m_id, m_ptr;
  bit         m_err, m_enc;
  logic [1:0] m_mode;

  logic [14:0] e, a;
  int          win;

  function automatic int nr_for(input logic [1:0] md);
    return (md == 2'b01) ? 12 : (md == 2'b10) ? 14 : 10;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_nr = 10; m_id = 0; m_ptr = NUM_REQ - 1;
    m_err = 0; m_enc = 0; m_mode = 2'b00;
  endtask

  task automatic predict(output logic [14:0] ev, output int w);
    logic [3:0] r; logic ld, lr, bz, dn, di, er; logic [1:0] rdy;
    w = -1;
    if (!m_busy && !abort)
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    rdy = (w >= 0) ? 2'(1 << w) : 2'b00;
    r = 4'd0; ld = 0; lr = 0; bz = 0; dn = 0; di = 0; er = 0;
    if (m_busy) begin
      r  = 4'(m_age);
      ld = (m_age == 0);
      lr = (m_age == m_nr);
      bz = 1'b1;
      dn = (m_age == m_nr) && !abort;
      di = dn ? 1'(m_id) : 1'b0;
      er = dn && m_err;
    end
    ev = {r, ld, lr, bz, dn, di, er, rdy, m_mode, m_enc};
  endtask

  task automatic model_step(input int w);
    if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_age = 0; m_id = w; m_ptr = w;
        m_mode = req_mode[2*w +: 2]; m_enc = req_enc_dec[w];
        m_nr = nr_for(m_mode); m_err = (m_mode == 2'b11);
      end
    end else if (abort || m_age == m_nr) begin
      m_busy = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic sample(output logic [14:0] ev, output logic [14:0] av, output int w);
    #1;
    predict(ev, w);
    av = {round, load, last_round, busy, done, done_id, err, req_ready, mode_reg, enc_dec_reg};
  endtask

  task automatic advance(input int w);
    @(posedge clk);
    model_step(w);
    cyc_now++;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    req_valid = '0; abort = 0;
    for (int i = 0; i < 20; i++) begin
      sample(e, a, win);
      total++;
      if (a !== e) begin bad++; $display("FAIL %s_drain cyc=%0d got=%h want=%h", name, cyc_now, a, e); end
      advance(win);
      if (!m_busy) break;
    end
  endtask

  task automatic test_reset();
    reset = 1; req_valid = '0; req_mode = '0; req_enc_dec = '0; abort = 0;
    model_reset();
    #2;
    total++;
    if ({round, load, last_round, busy, done, done_id, err, req_ready, mode_reg, enc_dec_reg} !== 15'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
        {round, load, last_round, busy, done, done_id, err, req_ready, mode_reg, enc_dec_reg});
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic run_job(input string name, input int r, input logic [1:0] md, input bit en, input bit toggle);
    int acc, dn, nr;
    acc = -1; dn = -1; nr = nr_for(md);
    abort = 0;
    req_valid = 2'(1 << r);
    req_mode = 4'($urandom); req_mode[2*r +: 2] = md;
    req_enc_dec = 2'($urandom); req_enc_dec[r] = en;
    for (int i = 0; i < 40; i++) begin
      sample(e, a, win);
      total++;
      if (a !== e) begin bad++; $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc_now, a, e); end
      if (win >= 0) acc = cyc_now;
      if (done === 1'b1) dn = cyc_now;
      advance(win);
      if (m_busy) begin
        req_valid = '0;
        if (toggle) begin req_mode = 4'($urandom); req_enc_dec = 2'($urandom); end
      end
      if (dn >= 0) break;
    end
    total++;
    if (acc < 0 || dn < 0 || dn - acc != nr + 1) begin
      bad++; $display("FAIL %s_latency got=%0d want=%0d", name, dn - acc, nr + 1);
    end
    sample(e, a, win);
    total++;
    if (busy !== 1'b0 || mode_reg !== md || enc_dec_reg !== en) begin
      bad++; $display("FAIL %s_after busy=%b mode=%b enc=%b want busy=0 mode=%b enc=%b",
        name, busy, mode_reg, enc_dec_reg, md, en);
    end
  endtask

  task automatic test_enc128();   run_job("enc128", 0, 2'b00, 1'b1, 1'b0); endtask
  task automatic test_dec256();   run_job("dec256", 1, 2'b10, 1'b0, 1'b0); endtask
  task automatic test_reserved(); run_job("reserved", 0, 2'b11, 1'b1, 1'b1); endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 6; j++)
      run_job("randjob", $urandom_range(0, 1), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    int ids[$], accs[$];
    int exp_ids[4] = '{0, 1, 0, 1};
    req_valid = 2'b11; req_mode = 4'b0101; req_enc_dec = 2'($urandom); abort = 0;
    for (int i = 0; i < 80 && accs.size() < 4; i++) begin
      sample(e, a, win);
      total++;
      if (a !== e) begin bad++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc_now, a, e); end
      if (req_ready !== 2'b00) begin ids.push_back(req_ready == 2'b10 ? 1 : 0); accs.push_back(cyc_now); end
      advance(win);
    end
    total++;
    if (ids.size() != 4) begin
      bad++; $display("FAIL b2b_count got=%0d want=4", ids.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (ids[k] != exp_ids[k]) begin bad++; $display("FAIL b2b_id[%0d] got=%0d want=%0d", k, ids[k], exp_ids[k]); end
        if (k > 0) begin
          total++;
          if (accs[k] - accs[k-1] != 14) begin
            bad++; $display("FAIL b2b_gap[%0d] got=%0d want=14", k, accs[k] - accs[k-1]);
          end
        end
      end
    end
    drain("b2b");
  endtask

  task automatic test_abort();
    bit hit;
    hit = 0;
    req_valid = 2'b01; req_mode = {2'b00, 2'($urandom_range(0, 2))}; req_enc_dec = 2'($urandom); abort = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_busy && m_age == 5) begin abort = 1; req_valid = 2'b10; hit = 1; end
      else if (m_busy) req_valid = '0;
      sample(e, a, win);
      total++;
      if (a !== e) begin bad++; $display("FAIL abort_run cyc=%0d got=%h want=%h", cyc_now, a, e); end
      advance(win);
      if (hit) break;
    end
    abort = 0;
    sample(e, a, win);
    total++;
    if (!hit || busy !== 1'b0 || round !== 4'd0 || done !== 1'b0 || req_ready !== 2'b10) begin
      bad++; $display("FAIL abort_idle busy=%b round=%0d done=%b ready=%b want 0 0 0 10",
        busy, round, done, req_ready);
    end
    advance(win);
    drain("abort");
  endtask

  task automatic test_reset_midjob();
    bit hit;
    hit = 0;
    req_valid = 2'b01; req_mode = 4'b0010; req_enc_dec = 2'b11; abort = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_busy && m_age == 7) begin hit = 1; break; end
      if (m_busy) req_valid = '0;
      sample(e, a, win);
      total++;
      if (a !== e) begin bad++; $display("FAIL rstmid_run cyc=%0d got=%h want=%h", cyc_now, a, e); end
      advance(win);
    end
    #2 reset = 1;
    #1;
    total++;
    if (!hit || busy !== 1'b0 || round !== 4'd0 || done !== 1'b0) begin
      bad++; $display("FAIL rstmid_async busy=%b round=%0d done=%b want 0 0 0", busy, round, done);
    end
    model_reset();
    #1 reset = 0;
    req_valid = '0;
    @(negedge clk);
    req_valid = 2'b11;
    sample(e, a, win);
    total++;
    if (a !== e || req_ready !== 2'b01) begin
      bad++; $display("FAIL rstmid_grant ready=%b got=%h want=%h", req_ready, a, e);
    end
    advance(win);
    drain("rstmid");
  endtask

  task automatic test_random_soak();
    for (int i = 0; i < 300; i++) begin
      req_valid = 2'($urandom); req_mode = 4'($urandom); req_enc_dec = 2'($urandom);
      abort = ($urandom_range(0, 15) == 0);
      sample(e, a, win);
      total++;
      if (a !== e) begin bad++; $display("FAIL soak cyc=%0d got=%h want=%h", cyc_now, a, e); end
      advance(win);
    end
    drain("soak");
  endtask

  initial begin
    test_reset();
    test_enc128();
    test_dec256();
    test_back_to_back();
    test_abort();
    test_reset_midjob();
    test_reserved();
    test_random_jobs();
    test_random_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_round_sched.md
Name: aes_round_sched

Overview:
Round sequencer and arbiter for the shared AES round datapath. It accepts encrypt/decrypt jobs from NUM_REQ requesters over a valid/ready handshake and picks between them round-robin. For the granted job it latches key size and direction, then drives the round index for 10, 12 or 14 rounds (AES-128/192/256). It sits between the requesters and the round datapath/key expander, and it generalises the fixed 128-bit round sequencing to all key sizes.

Parameters:
NUM_REQ, 2, number of requesters (2..8); ID_W = $clog2(NUM_REQ) is a derived localparam.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
req_valid  in  NUM_REQ  per-requester job request
req_ready  out  NUM_REQ  one-hot; a job is accepted in a cycle where req_valid[i] & req_ready[i]
req_mode  in  2*NUM_REQ  per-requester key size: 00=128, 01=192, 10=256, 11=reserved
req_enc_dec  in  NUM_REQ  per-requester direction, 1=encrypt
abort  in  1  synchronous job cancel
round  out  4  current round index to the datapath
load  out  1  round-0 pulse: datapath loads state and key
last_round  out  1  high when round==Nr (final round, no MixColumns)
enc_dec_reg  out  1  latched direction of the active job
mode_reg  out  2  latched key size of the active job
busy  out  1  a job is active (any state except IDLE)
done  out  1  one-cycle completion pulse
done_id  out  ID_W  requester index of the completing job; valid only with done
err  out  1  pulse with done when the job used the reserved mode

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE; all outputs 0; rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE -> LOAD -> RUN -> FINAL -> IDLE.
- IDLE: round=0, busy=0, load=0.
  - If abort=0 and any req_valid is set, assert req_ready for the winner only (combinational, same cycle).
  - Winner = first set req_valid scanning from rr_ptr+1, modulo NUM_REQ.
  - On accept: latch mode_reg, enc_dec_reg, job_id and Nr; set rr_ptr=winner; next state LOAD.
  - abort=1 in IDLE: req_ready all 0 that cycle.
- req_ready is 0 in every state except IDLE.
- Nr: 10 for 00, 12 for 01, 14 for 10. Reserved 11 runs with Nr=10 and sets an err flag, reported on completion.
- LOAD: round=0, load=1, busy=1; next state RUN.
- RUN: round counts 1..Nr-1, incrementing by 1 per cycle. When round==Nr-1, next state FINAL.
- FINAL: round=Nr, last_round=1, done=1, done_id=job_id, err=flag; next state IDLE.
- Latency and throughput:
  - Acceptance at cycle T gives LOAD at T+1 and done at T+Nr+1.
  - Earliest next acceptance is T+Nr+2.
- Latched outputs are stable for the whole job; req_mode and req_enc_dec changes during a job are ignored. enc_dec_reg and mode_reg hold their value in IDLE until the next acceptance.
- abort=1 in LOAD, RUN or FINAL:
  - next state IDLE; round returns to 0;
  - no done pulse, and done is suppressed in that cycle if in FINAL;
  - rr_ptr keeps the aborted job's id.
- Reset mid-job: the job is lost and no done is produced. Requesters must re-request.
- round never exceeds 14; all round arithmetic is 4-bit unsigned with no wrap.

Decomposition:
- Package aes_pkg:
  - enum key_size_e {KS_128, KS_192, KS_256, KS_RSVD};
  - enum sched_state_e {IDLE, LOAD, RUN, FINAL};
  - localparams NR_128=10, NR_192=12, NR_256=14;
  - function nr_of(key_size_e) returns 4 bits.
- Sub-module aes_rr_arbiter (NUM_REQ): inputs req, ptr, en; outputs one-hot grant and grant index. Purely combinational; rr_ptr is held in aes_round_sched.

Test Plan:
1. req_valid=01, req_mode[0]=00, enc=1 at cycle 5 -> req_ready=01 at 5; load=1, round=0 at 6; round 1..9 at cycles 7-15; round=10, last_round=1, done=1, done_id=0 at 16; busy=0 at 17.
2. Requester 1, mode 10, enc=0 -> round reaches 14; done at acceptance+15; enc_dec_reg=0 throughout; mode_reg=10.
3. Both requesters valid continuously, mode 01 -> grants 0,1,0,1; done_id alternates; acceptances 14 cycles apart.
4. abort=1 while round=5 -> next cycle IDLE, round=0, busy=0, no done; a pending req_valid is accepted in the following IDLE cycle.
5. reset asserted between clock edges during round 7 -> busy, round and done go to 0 before the next edge; after release, with both requesters valid, requester 0 is granted.
6. mode 11 -> 10 rounds, err=1 together with done; toggling req_mode and req_enc_dec mid-job leaves mode_reg=11 and enc_dec_reg unchanged.
